// File: rtl/gps_seq_pkg.sv
// gps_seq_pkg
// Shared definitions for the GPS scenario sequencer: the sequencer state
// encoding, the width of one scenario table entry and the bit positions of
// each configuration field inside an entry.
package gps_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_APPLY   = 3'd2,
        S_START   = 3'd3,
        S_WAIT_PH = 3'd4,
        S_DWELL   = 3'd5,
        S_NEXT    = 3'd6,
        S_FINISH  = 3'd7
    } seq_state_t;

    localparam int ENTRY_W = 45;

    localparam int NSAT_MSB  = 44;
    localparam int NSAT_LSB  = 40;
    localparam int DOP_MSB   = 39;
    localparam int DOP_LSB   = 32;
    localparam int SNR_MSB   = 31;
    localparam int SNR_LSB   = 24;
    localparam int PHASE_MSB = 23;
    localparam int PHASE_LSB = 8;
    localparam int DWELL_MSB = 7;
    localparam int DWELL_LSB = 0;

endpackage

// File: rtl/seq_table_ram.sv
// seq_table_ram
// Scenario table storage: DEPTH x ENTRY_W, one synchronous write port and
// one synchronous read port. A read and a write to the same address in the
// same cycle return the previous contents. Contents are not reset.
// Ports:
//   clk_in   - clock
//   we_i     - write strobe
//   waddr_i  - write address
//   wdata_i  - write data
//   re_i     - read strobe; data appears on rdata_o the following cycle
//   raddr_i  - read address
//   rdata_o  - registered read data
module seq_table_ram
    import gps_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk_in,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic               re_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] rdata_q;

    // Both ports update with non-blocking assignments in one process, so a
    // colliding read always sees the value held before this edge.
    always_ff @(posedge clk_in) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gps_scenario_seq.sv
// gps_scenario_seq
// Scenario sequencer for the GPS signal generator core. Steps the core
// through a table of satellite configurations: for each entry it drives the
// configuration, pulses the code-phase start, waits for code_phase_done and
// then dwells a programmed number of core epochs before the next entry.
// Ports:
//   clk_in, rst_in_n        - clock, synchronous active-low reset
//   cfg_we_in/addr/data     - table write port (accepted in any state)
//   num_entries_in          - number of active entries (0..DEPTH)
//   run_in                  - level: rising edge starts, low aborts
//   loop_in                 - wrap to entry 0 after the last entry
//   epoch_in                - epoch pulse from the core
//   code_phase_done_in      - code-phase alignment done pulse from the core
//   ena_out                 - core enable
//   n_sat/doppler/snr/ca_phase_out - core configuration
//   ca_phase_start_out      - one-cycle code-phase start pulse
//   entry_idx_out           - current entry index
//   busy_out, done_out      - run active, one-cycle completion pulse
//   err_out                 - sticky code-phase timeout flag
module gps_scenario_seq
    import gps_seq_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int AW            = 3,
    parameter int PHASE_TIMEOUT = 65535
) (
    input  logic               clk_in,
    input  logic               rst_in_n,
    input  logic               cfg_we_in,
    input  logic [AW-1:0]      cfg_addr_in,
    input  logic [ENTRY_W-1:0] cfg_data_in,
    input  logic [AW:0]        num_entries_in,
    input  logic               run_in,
    input  logic               loop_in,
    input  logic               epoch_in,
    input  logic               code_phase_done_in,
    output logic               ena_out,
    output logic [4:0]         n_sat_out,
    output logic [7:0]         doppler_out,
    output logic [7:0]         snr_out,
    output logic [15:0]        ca_phase_out,
    output logic               ca_phase_start_out,
    output logic [AW-1:0]      entry_idx_out,
    output logic               busy_out,
    output logic               done_out,
    output logic               err_out
);

    localparam int TW = (PHASE_TIMEOUT > 1) ? $clog2(PHASE_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(PHASE_TIMEOUT - 1);

    seq_state_t         state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [7:0]         dwell_cnt_q, dwell_cnt_d;
    logic [TW-1:0]      to_cnt_q, to_cnt_d;
    logic               run_q;
    logic               err_q, err_d;
    logic               ena_q, ena_d;
    logic               zdone_q, zdone_d;
    logic [4:0]         n_sat_q;
    logic [7:0]         doppler_q, snr_q, dwell_q;
    logic [15:0]        ca_phase_q;
    logic               load_cfg;
    logic               rd_en;
    logic               idx_last;
    logic [ENTRY_W-1:0] rd_data;

    seq_table_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk_in  (clk_in),
        .we_i    (cfg_we_in),
        .waddr_i (cfg_addr_in),
        .wdata_i (cfg_data_in),
        .re_i    (rd_en),
        .raddr_i (idx_q),
        .rdata_o (rd_data)
    );

    // Also true when the index is past the end because num_entries shrank
    // mid-run, so the sequence always terminates.
    assign idx_last = ({1'b0, idx_q} + (AW + 1)'(1)) >= num_entries_in;

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            dwell_cnt_q <= '0;
            to_cnt_q    <= '0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
            ena_q       <= 1'b0;
            zdone_q     <= 1'b0;
            n_sat_q     <= '0;
            doppler_q   <= '0;
            snr_q       <= '0;
            ca_phase_q  <= '0;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dwell_cnt_q <= dwell_cnt_d;
            to_cnt_q    <= to_cnt_d;
            run_q       <= run_in;
            err_q       <= err_d;
            ena_q       <= ena_d;
            zdone_q     <= zdone_d;
            if (load_cfg) begin
                n_sat_q    <= rd_data[NSAT_MSB:NSAT_LSB];
                doppler_q  <= rd_data[DOP_MSB:DOP_LSB];
                snr_q      <= rd_data[SNR_MSB:SNR_LSB];
                ca_phase_q <= rd_data[PHASE_MSB:PHASE_LSB];
                dwell_q    <= rd_data[DWELL_MSB:DWELL_LSB];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dwell_cnt_d = dwell_cnt_q;
        to_cnt_d    = to_cnt_q;
        err_d       = err_q;
        ena_d       = ena_q;
        zdone_d     = 1'b0;
        load_cfg    = 1'b0;
        rd_en       = 1'b0;

        if (state_q != S_IDLE && !run_in) begin
            // Abort: drop straight to IDLE, index kept until the next start.
            state_d = S_IDLE;
            ena_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_in && !run_q) begin
                        err_d = 1'b0;
                        idx_d = '0;
                        if (num_entries_in != '0) begin
                            state_d = S_LOAD;
                        end else begin
                            zdone_d = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    rd_en   = 1'b1;
                    state_d = S_APPLY;
                end
                S_APPLY: begin
                    load_cfg = 1'b1;
                    ena_d    = 1'b1;
                    state_d  = S_START;
                end
                S_START: begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_PH;
                end
                S_WAIT_PH: begin
                    if (code_phase_done_in) begin
                        if (dwell_q == 8'd0) begin
                            state_d = S_NEXT;
                        end else begin
                            dwell_cnt_d = dwell_q;
                            state_d     = S_DWELL;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_NEXT;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                end
                S_DWELL: begin
                    if (epoch_in) begin
                        if (dwell_cnt_q == 8'd1) begin
                            state_d = S_NEXT;
                        end else begin
                            dwell_cnt_d = dwell_cnt_q - 8'd1;
                        end
                    end
                end
                S_NEXT: begin
                    if (idx_last) begin
                        if (loop_in) begin
                            idx_d   = '0;
                            state_d = S_LOAD;
                        end else begin
                            ena_d   = 1'b0;
                            state_d = S_FINISH;
                        end
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_LOAD;
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Enable is raised combinationally in APPLY so the core sees it in the
    // same cycle the configuration is captured.
    assign ena_out            = ena_q || (state_q == S_APPLY);
    assign ca_phase_start_out = (state_q == S_START) && run_in;
    assign done_out           = zdone_q || ((state_q == S_FINISH) && run_in);
    assign busy_out           = (state_q != S_IDLE);
    assign err_out            = err_q;
    assign entry_idx_out      = idx_q;
    assign n_sat_out          = n_sat_q;
    assign doppler_out        = doppler_q;
    assign snr_out            = snr_q;
    assign ca_phase_out       = ca_phase_q;

endmodule

// File: tb/tb_gps_scenario_seq.sv
// tb_gps_scenario_seq
// Directed bench for gps_scenario_seq. Background processes model the core:
// a code_phase_done responder (5 cycles after each start) and a free-running
// epoch generator (one pulse every 20 cycles while enabled).
module tb_gps_scenario_seq;

    logic        clk_in = 1'b0;
    logic        rst_in_n;
    logic        cfg_we_in;
    logic [2:0]  cfg_addr_in;
    logic [44:0] cfg_data_in;
    logic [3:0]  num_entries_in;
    logic        run_in;
    logic        loop_in;
    logic        epoch_in;
    logic        code_phase_done_in;
    logic        ena_out;
    logic [4:0]  n_sat_out;
    logic [7:0]  doppler_out;
    logic [7:0]  snr_out;
    logic [15:0] ca_phase_out;
    logic        ca_phase_start_out;
    logic [2:0]  entry_idx_out;
    logic        busy_out;
    logic        done_out;
    logic        err_out;

    int checks = 0;
    int failures = 0;
    int done_total = 0;
    int ep_total = 0;
    int idx_log[$];
    logic resp_en = 1'b0;
    logic epoch_en = 1'b0;

    gps_scenario_seq #(
        .DEPTH         (8),
        .AW            (3),
        .PHASE_TIMEOUT (16)
    ) dut (
        .clk_in             (clk_in),
        .rst_in_n           (rst_in_n),
        .cfg_we_in          (cfg_we_in),
        .cfg_addr_in        (cfg_addr_in),
        .cfg_data_in        (cfg_data_in),
        .num_entries_in     (num_entries_in),
        .run_in             (run_in),
        .loop_in            (loop_in),
        .epoch_in           (epoch_in),
        .code_phase_done_in (code_phase_done_in),
        .ena_out            (ena_out),
        .n_sat_out          (n_sat_out),
        .doppler_out        (doppler_out),
        .snr_out            (snr_out),
        .ca_phase_out       (ca_phase_out),
        .ca_phase_start_out (ca_phase_start_out),
        .entry_idx_out      (entry_idx_out),
        .busy_out           (busy_out),
        .done_out           (done_out),
        .err_out            (err_out)
    );

    always #5 clk_in = ~clk_in;

    // Core model: code_phase_done 5 cycles after each start.
    initial begin
        code_phase_done_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (resp_en && ca_phase_start_out) begin
                repeat (4) @(negedge clk_in);
                code_phase_done_in = 1'b1;
                @(negedge clk_in);
                code_phase_done_in = 1'b0;
            end
        end
    end

    // Core model: epoch pulse every 20 cycles, phase restarts on enable.
    initial begin
        int ecnt;
        ecnt = 0;
        epoch_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!epoch_en) begin
                ecnt = 0;
                epoch_in = 1'b0;
            end else begin
                ecnt++;
                if (ecnt == 20) begin
                    epoch_in = 1'b1;
                    ecnt = 0;
                    ep_total++;
                end else begin
                    epoch_in = 1'b0;
                end
            end
        end
    end

    // Event monitor.
    initial begin
        forever begin
            @(negedge clk_in);
            if (done_out) done_total++;
            if (ca_phase_start_out) idx_log.push_back(int'(entry_idx_out));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    function automatic logic [44:0] mk(input logic [4:0] s, input logic [7:0] d,
                                       input logic [7:0] r, input logic [15:0] p,
                                       input logic [7:0] w);
        return {s, d, r, p, w};
    endfunction

    task automatic write_entry(input logic [2:0] a, input logic [44:0] data);
        cfg_we_in = 1'b1;
        cfg_addr_in = a;
        cfg_data_in = data;
        tick(1);
        cfg_we_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in_n = 1'b0;
        tick(3);
        checks++;
        if ({ena_out, ca_phase_start_out, busy_out, done_out, err_out} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {ena_out, ca_phase_start_out, busy_out, done_out, err_out});
        end
        checks++;
        if ({n_sat_out, doppler_out, snr_out, ca_phase_out, entry_idx_out} !== 40'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0",
                     {n_sat_out, doppler_out, snr_out, ca_phase_out, entry_idx_out});
        end
        rst_in_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        int n, ep0, d0;
        write_entry(3'd0, mk(5'd3, 8'h10, 8'h20, 16'h0100, 8'd2));
        write_entry(3'd1, mk(5'd7, 8'h11, 8'h21, 16'h0200, 8'd1));
        num_entries_in = 4'd2;
        loop_in = 1'b0;
        resp_en = 1'b1;
        d0 = done_total;
        ep0 = ep_total;
        run_in = 1'b1;
        epoch_en = 1'b1;
        tick(2);
        checks++;
        if (ca_phase_start_out !== 1'b0) begin
            failures++;
            $display("FAIL basic_start_early: got %b expected 0", ca_phase_start_out);
        end
        tick(1);
        checks++;
        if (ca_phase_start_out !== 1'b1) begin
            failures++;
            $display("FAIL basic_start_latency: got %b expected 1", ca_phase_start_out);
        end
        checks++;
        if ({n_sat_out, doppler_out, snr_out, ca_phase_out} !== {5'd3, 8'h10, 8'h20, 16'h0100}) begin
            failures++;
            $display("FAIL basic_entry0_cfg: got %h expected %h",
                     {n_sat_out, doppler_out, snr_out, ca_phase_out}, {5'd3, 8'h10, 8'h20, 16'h0100});
        end
        checks++;
        if ({ena_out, busy_out, entry_idx_out} !== 5'b11_000) begin
            failures++;
            $display("FAIL basic_ena_busy_idx: got %b expected 11000", {ena_out, busy_out, entry_idx_out});
        end
        n = 0;
        while (!(ca_phase_start_out && entry_idx_out == 3'd1) && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (!(ca_phase_start_out && entry_idx_out == 3'd1)) begin
            failures++;
            $display("FAIL basic_entry1_start: got no start within %0d cycles, required one", n);
        end
        checks++;
        if ({n_sat_out, doppler_out, snr_out, ca_phase_out} !== {5'd7, 8'h11, 8'h21, 16'h0200}) begin
            failures++;
            $display("FAIL basic_entry1_cfg: got %h expected %h",
                     {n_sat_out, doppler_out, snr_out, ca_phase_out}, {5'd7, 8'h11, 8'h21, 16'h0200});
        end
        checks++;
        if (ep_total - ep0 !== 2) begin
            failures++;
            $display("FAIL basic_entry1_after_epochs: got %0d epochs expected 2", ep_total - ep0);
        end
        n = 0;
        while (!done_out && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (done_out !== 1'b1) begin
            failures++;
            $display("FAIL basic_done: got %b expected 1", done_out);
        end
        checks++;
        if (ep_total - ep0 !== 3) begin
            failures++;
            $display("FAIL basic_done_epochs: got %0d epochs expected 3", ep_total - ep0);
        end
        checks++;
        if (ena_out !== 1'b0) begin
            failures++;
            $display("FAIL basic_ena_at_finish: got %b expected 0", ena_out);
        end
        tick(3);
        checks++;
        if (done_total - d0 !== 1) begin
            failures++;
            $display("FAIL basic_done_count: got %0d expected 1", done_total - d0);
        end
        checks++;
        if ({busy_out, ena_out, n_sat_out} !== {2'b00, 5'd7}) begin
            failures++;
            $display("FAIL basic_idle_hold: got %b expected 0000111", {busy_out, ena_out, n_sat_out});
        end
        run_in = 1'b0;
        epoch_en = 1'b0;
        tick(3);
    endtask

    task automatic test_loop();
        int n, d0, s0;
        int exp_idx[4] = '{0, 1, 0, 1};
        d0 = done_total;
        s0 = idx_log.size();
        loop_in = 1'b1;
        run_in = 1'b1;
        epoch_en = 1'b1;
        n = 0;
        while (idx_log.size() < s0 + 4 && n < 600) begin
            tick(1);
            n++;
        end
        checks++;
        if (idx_log.size() < s0 + 4) begin
            failures++;
            $display("FAIL loop_starts: got %0d starts expected 4", idx_log.size() - s0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (idx_log[s0 + i] !== exp_idx[i]) begin
                    failures++;
                    $display("FAIL loop_idx%0d: got %0d expected %0d", i, idx_log[s0 + i], exp_idx[i]);
                end
            end
        end
        tick(6);
        checks++;
        if ({busy_out, ena_out, entry_idx_out} !== 5'b11_001) begin
            failures++;
            $display("FAIL loop_in_dwell: got %b expected 11001", {busy_out, ena_out, entry_idx_out});
        end
        run_in = 1'b0;
        tick(1);
        checks++;
        if ({busy_out, ena_out, ca_phase_start_out} !== 3'b000) begin
            failures++;
            $display("FAIL abort_idle: got %b expected 000", {busy_out, ena_out, ca_phase_start_out});
        end
        tick(30);
        checks++;
        if (done_total - d0 !== 0) begin
            failures++;
            $display("FAIL loop_abort_no_done: got %0d expected 0", done_total - d0);
        end
        checks++;
        if ({32'(idx_log.size() - s0), 29'd0, entry_idx_out} !== {32'd4, 29'd0, 3'd1}) begin
            failures++;
            $display("FAIL abort_quiet: got starts=%0d idx=%0d expected starts=4 idx=1",
                     idx_log.size() - s0, entry_idx_out);
        end
        loop_in = 1'b0;
        epoch_en = 1'b0;
        tick(3);
    endtask

    task automatic test_dwell_zero();
        int n, ep0;
        write_entry(3'd0, mk(5'd1, 8'h30, 8'h40, 16'h0300, 8'd0));
        write_entry(3'd1, mk(5'd7, 8'h11, 8'h21, 16'h0200, 8'd1));
        num_entries_in = 4'd2;
        ep0 = ep_total;
        run_in = 1'b1;
        epoch_en = 1'b1;
        tick(3);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!ca_phase_start_out && n < 50);
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL dwell0_gap: got %0d cycles expected 8", n);
        end
        checks++;
        if ({29'd0, entry_idx_out} !== 32'd1 || ep_total - ep0 !== 0) begin
            failures++;
            $display("FAIL dwell0_no_epoch: got idx=%0d epochs=%0d expected idx=1 epochs=0",
                     entry_idx_out, ep_total - ep0);
        end
        n = 0;
        while (!done_out && n < 100) begin
            tick(1);
            n++;
        end
        checks++;
        if (done_out !== 1'b1) begin
            failures++;
            $display("FAIL dwell0_done: got %b expected 1", done_out);
        end
        run_in = 1'b0;
        epoch_en = 1'b0;
        tick(3);
    endtask

    task automatic test_empty();
        num_entries_in = 4'd0;
        run_in = 1'b1;
        tick(1);
        checks++;
        if ({done_out, busy_out, ena_out} !== 3'b100) begin
            failures++;
            $display("FAIL empty_done: got %b expected 100", {done_out, busy_out, ena_out});
        end
        tick(1);
        checks++;
        if ({done_out, busy_out, ena_out, ca_phase_start_out} !== 4'b0000) begin
            failures++;
            $display("FAIL empty_after: got %b expected 0000",
                     {done_out, busy_out, ena_out, ca_phase_start_out});
        end
        run_in = 1'b0;
        tick(2);
    endtask

    task automatic test_write_during_run();
        int n;
        write_entry(3'd0, mk(5'd3, 8'h10, 8'h20, 16'h0100, 8'd2));
        num_entries_in = 4'd2;
        run_in = 1'b1;
        epoch_en = 1'b1;
        tick(3);
        tick(6);
        // Entry 0 is dwelling here.
        write_entry(3'd1, mk(5'd9, 8'h55, 8'h66, 16'hABCD, 8'd1));
        n = 0;
        while (entry_idx_out !== 3'd1 && n < 200) begin
            tick(1);
            n++;
        end
        // Index just advanced: the table read is issued this cycle.
        cfg_we_in = 1'b1;
        cfg_addr_in = 3'd1;
        cfg_data_in = mk(5'd2, 8'h77, 8'h88, 16'h1234, 8'd1);
        tick(1);
        cfg_we_in = 1'b0;
        n = 0;
        while (!ca_phase_start_out && n < 20) begin
            tick(1);
            n++;
        end
        checks++;
        if ({n_sat_out, doppler_out, snr_out, ca_phase_out} !== {5'd9, 8'h55, 8'h66, 16'hABCD}) begin
            failures++;
            $display("FAIL wr_collision_old: got %h expected %h",
                     {n_sat_out, doppler_out, snr_out, ca_phase_out}, {5'd9, 8'h55, 8'h66, 16'hABCD});
        end
        write_entry(3'd1, mk(5'd4, 8'h99, 8'hAA, 16'h5678, 8'd1));
        checks++;
        if ({n_sat_out, doppler_out, snr_out, ca_phase_out} !== {5'd9, 8'h55, 8'h66, 16'hABCD}) begin
            failures++;
            $display("FAIL wr_latched_hold: got %h expected %h",
                     {n_sat_out, doppler_out, snr_out, ca_phase_out}, {5'd9, 8'h55, 8'h66, 16'hABCD});
        end
        run_in = 1'b0;
        tick(2);
        run_in = 1'b1;
        n = 0;
        while (!(ca_phase_start_out && entry_idx_out == 3'd1) && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if ({n_sat_out, doppler_out, snr_out, ca_phase_out} !== {5'd4, 8'h99, 8'hAA, 16'h5678}) begin
            failures++;
            $display("FAIL wr_new_data: got %h expected %h",
                     {n_sat_out, doppler_out, snr_out, ca_phase_out}, {5'd4, 8'h99, 8'hAA, 16'h5678});
        end
        run_in = 1'b0;
        epoch_en = 1'b0;
        tick(3);
    endtask

    task automatic test_timeout();
        int n;
        resp_en = 1'b0;
        epoch_en = 1'b0;
        num_entries_in = 4'd2;
        run_in = 1'b1;
        tick(3);
        checks++;
        if ({ca_phase_start_out, entry_idx_out} !== 4'b1_000) begin
            failures++;
            $display("FAIL to_first_start: got %b expected 1000", {ca_phase_start_out, entry_idx_out});
        end
        tick(16);
        checks++;
        if (err_out !== 1'b0) begin
            failures++;
            $display("FAIL to_err_early: got %b expected 0", err_out);
        end
        tick(1);
        checks++;
        if (err_out !== 1'b1) begin
            failures++;
            $display("FAIL to_err_set: got %b expected 1", err_out);
        end
        tick(3);
        checks++;
        if ({ca_phase_start_out, entry_idx_out} !== 4'b1_001) begin
            failures++;
            $display("FAIL to_advance: got %b expected 1001", {ca_phase_start_out, entry_idx_out});
        end
        n = 0;
        while (!done_out && n < 100) begin
            tick(1);
            n++;
        end
        checks++;
        if ({done_out, err_out} !== 2'b11) begin
            failures++;
            $display("FAIL to_done_err: got %b expected 11", {done_out, err_out});
        end
        run_in = 1'b0;
        tick(3);
        checks++;
        if (err_out !== 1'b1) begin
            failures++;
            $display("FAIL to_err_sticky: got %b expected 1", err_out);
        end
        resp_en = 1'b1;
        run_in = 1'b1;
        tick(1);
        checks++;
        if (err_out !== 1'b0) begin
            failures++;
            $display("FAIL to_err_clear: got %b expected 0", err_out);
        end
        run_in = 1'b0;
        tick(3);
    endtask

    initial begin
        rst_in_n = 1'b0;
        cfg_we_in = 1'b0;
        cfg_addr_in = 3'd0;
        cfg_data_in = '0;
        num_entries_in = 4'd0;
        run_in = 1'b0;
        loop_in = 1'b0;
        tick(1);
        test_reset();
        test_basic();
        test_loop();
        test_dwell_zero();
        test_empty();
        test_write_during_run();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
